// File: rtl/diffeq_iter_solver_if.sv
// Handshake and result bus of the iterative diffeq solver.
interface diffeq_iter_solver_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_ITER = 1024
);
    localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);

    logic                     start;
    logic signed [WIDTH-1:0]  x0;
    logic signed [WIDTH-1:0]  y0;
    logic signed [WIDTH-1:0]  u0;
    logic signed [WIDTH-1:0]  aport;
    logic signed [WIDTH-1:0]  dxport;
    logic                     busy;
    logic                     done;
    logic                     timeout;
    logic [ITER_W-1:0]        iter_count;
    logic signed [WIDTH-1:0]  xport;
    logic signed [WIDTH-1:0]  yport;
    logic signed [WIDTH-1:0]  uport;
    logic signed [WIDTH-1:0]  sum_out;

    modport master (
        output start, x0, y0, u0, aport, dxport,
        input  busy, done, timeout, iter_count, xport, yport, uport, sum_out
    );

    modport slave (
        input  start, x0, y0, u0, aport, dxport,
        output busy, done, timeout, iter_count, xport, yport, uport, sum_out
    );
endinterface

// File: rtl/diffeq_iter_solver.sv
// Forward-Euler solver for y'' + 3xy' + 3y = 0, one iteration per clock.
// Optional feature macro: DIFFEQ_SAT_EN (saturate u/y updates instead of wrapping).
module diffeq_iter_solver #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_ITER = 1024
) (
    input  logic clk,
    input  logic reset,
    diffeq_iter_solver_if.slave bus
);
    localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);
    // Full-precision width for the triple product plus headroom for the subtractions.
    localparam int unsigned PW     = 3 * WIDTH + 4;
    localparam logic signed [PW-1:0] K3 = PW'(3);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic signed [WIDTH-1:0] r_u;
    logic signed [WIDTH-1:0] r_a;
    logic signed [WIDTH-1:0] r_dx;
    logic [ITER_W-1:0]       r_iter;
    logic                    r_done;
    logic                    r_timeout;

    logic                    w_busy;
    logic                    w_accept;
    logic                    w_x_lt_a;
    logic                    w_iter_ok;
    logic                    w_step;
    logic                    w_finish;
    logic signed [PW-1:0]    w_xe;
    logic signed [PW-1:0]    w_ye;
    logic signed [PW-1:0]    w_ue;
    logic signed [PW-1:0]    w_dxe;
    logic signed [WIDTH-1:0] w_u_next;
    logic signed [WIDTH-1:0] w_y_next;

    // Sign-extend operands so every product is exact.
    assign w_xe  = PW'(r_x);
    assign w_ye  = PW'(r_y);
    assign w_ue  = PW'(r_u);
    assign w_dxe = PW'(r_dx);

`ifdef DIFFEQ_SAT_EN
    localparam logic signed [PW-1:0] SMAX = PW'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic signed [PW-1:0] SMIN = ~SMAX;

    logic signed [PW-1:0] w_u_full;
    logic signed [PW-1:0] w_y_full;

    assign w_u_full = w_ue - K3 * w_xe * w_ue * w_dxe - K3 * w_ye * w_dxe;
    assign w_y_full = w_ye + w_ue * w_dxe;

    // Clamp full-precision u/y updates to the signed WIDTH range.
    always_comb begin
        w_u_next = WIDTH'(w_u_full);
        w_y_next = WIDTH'(w_y_full);
        if (w_u_full > SMAX)      w_u_next = WIDTH'(SMAX);
        else if (w_u_full < SMIN) w_u_next = WIDTH'(SMIN);
        if (w_y_full > SMAX)      w_y_next = WIDTH'(SMAX);
        else if (w_y_full < SMIN) w_y_next = WIDTH'(SMIN);
    end
`else
    assign w_u_next = WIDTH'(w_ue - K3 * w_xe * w_ue * w_dxe - K3 * w_ye * w_dxe);
    assign w_y_next = WIDTH'(w_ye + w_ue * w_dxe);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state: start accepted only in IDLE, run ends on x>=a or iteration cap.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_RUN;
            S_RUN:   if (w_finish)  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Per-state control decodes.
    always_comb begin
        w_busy    = (r_state == S_RUN);
        w_accept  = (r_state == S_IDLE) && bus.start;
        w_x_lt_a  = (r_x < r_a);
        w_iter_ok = (r_iter < ITER_W'(MAX_ITER));
        w_step    = w_busy && w_x_lt_a && w_iter_ok;
        w_finish  = w_busy && !(w_x_lt_a && w_iter_ok);
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_u       <= '0;
            r_a       <= '0;
            r_dx      <= '0;
            r_iter    <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_x       <= bus.x0;
                r_y       <= bus.y0;
                r_u       <= bus.u0;
                r_a       <= bus.aport;
                r_dx      <= bus.dxport;
                r_iter    <= '0;
                r_timeout <= 1'b0;
            end else if (w_step) begin
                r_x    <= r_x + r_dx;
                r_y    <= w_y_next;
                r_u    <= w_u_next;
                r_iter <= r_iter + ITER_W'(1);
            end else if (w_finish) begin
                r_done <= 1'b1;
                if (w_x_lt_a) r_timeout <= 1'b1;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = r_done;
    assign bus.timeout    = r_timeout;
    assign bus.iter_count = r_iter;
    assign bus.xport      = r_x;
    assign bus.yport      = r_y;
    assign bus.uport      = r_u;
    assign bus.sum_out    = r_x + r_y + r_u;
endmodule

// File: tb/tb_diffeq_iter_solver.sv
// Directed bench for diffeq_iter_solver with an expected-result scoreboard.
module tb_diffeq_iter_solver;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    diffeq_iter_solver_if #(.WIDTH(32), .MAX_ITER(1024)) if_a ();
    diffeq_iter_solver_if #(.WIDTH(32), .MAX_ITER(16))   if_m ();
    diffeq_iter_solver_if #(.WIDTH(8),  .MAX_ITER(1024)) if_b ();

    diffeq_iter_solver #(.WIDTH(32), .MAX_ITER(1024)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    diffeq_iter_solver #(.WIDTH(32), .MAX_ITER(16))   dut_m (.clk(clk), .reset(reset), .bus(if_m));
    diffeq_iter_solver #(.WIDTH(8),  .MAX_ITER(1024)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    typedef struct {
        string       tag;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] u;
        logic [31:0] s;
        logic [31:0] iters;
        logic [31:0] to;
        logic [31:0] lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] u, input logic [31:0] s, input logic [31:0] it,
                            input logic [31:0] to, input logic [31:0] lat);
        exp_t e;
        e.tag = tag; e.x = x; e.y = y; e.u = u; e.s = s;
        e.iters = it; e.to = to; e.lat = lat;
        sb.push_back(e);
    endtask

    // Waits (bounded) for done on the selected DUT; lat counts edges after the accepting edge.
    task automatic wait_done(input int sel, output int lat, output bit ok);
        bit d;
        lat = 0;
        ok  = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            lat++;
            case (sel)
                0:       d = if_a.done;
                1:       d = if_m.done;
                default: d = if_b.done;
            endcase
            if (d) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pops the oldest expectation and compares it against the selected DUT.
    task automatic wait_and_check(input int sel);
        int          lat;
        bit          ok;
        exp_t        e;
        logic [31:0] ox, oy, ou, os, oi, ot;
        wait_done(sel, lat, ok);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        case (sel)
            0: begin
                ox = if_a.xport; oy = if_a.yport; ou = if_a.uport; os = if_a.sum_out;
                oi = 32'(if_a.iter_count); ot = 32'(if_a.timeout);
            end
            1: begin
                ox = if_m.xport; oy = if_m.yport; ou = if_m.uport; os = if_m.sum_out;
                oi = 32'(if_m.iter_count); ot = 32'(if_m.timeout);
            end
            default: begin
                ox = {24'h0, if_b.xport}; oy = {24'h0, if_b.yport};
                ou = {24'h0, if_b.uport}; os = {24'h0, if_b.sum_out};
                oi = 32'(if_b.iter_count); ot = 32'(if_b.timeout);
            end
        endcase
        chk({e.tag, "_done_seen"}, 32'(ok), 32'd1);
        chk({e.tag, "_latency"}, 32'(lat), e.lat);
        chk({e.tag, "_x"}, ox, e.x);
        chk({e.tag, "_y"}, oy, e.y);
        chk({e.tag, "_u"}, ou, e.u);
        chk({e.tag, "_sum"}, os, e.s);
        chk({e.tag, "_iter"}, oi, e.iters);
        chk({e.tag, "_timeout"}, ot, e.to);
    endtask

    task automatic load_a(input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] u0,
                          input logic [31:0] a, input logic [31:0] dx);
        if_a.x0 = x0; if_a.y0 = y0; if_a.u0 = u0; if_a.aport = a; if_a.dxport = dx;
    endtask

    initial begin
        reset = 1'b1;
        if_a.start = 1'b0; load_a(0, 0, 0, 0, 0);
        if_m.start = 1'b0; if_m.x0 = '0; if_m.y0 = '0; if_m.u0 = '0; if_m.aport = '0; if_m.dxport = '0;
        if_b.start = 1'b0; if_b.x0 = '0; if_b.y0 = '0; if_b.u0 = '0; if_b.aport = '0; if_b.dxport = '0;
        tick();
        tick();
        chk("rst_busy",    32'(if_a.busy), 32'd0);
        chk("rst_done",    32'(if_a.done), 32'd0);
        chk("rst_timeout", 32'(if_a.timeout), 32'd0);
        chk("rst_iter",    32'(if_a.iter_count), 32'd0);
        chk("rst_x",       if_a.xport, 32'd0);
        chk("rst_y",       if_a.yport, 32'd0);
        chk("rst_u",       if_a.uport, 32'd0);
        reset = 1'b0;
        tick();

        // Case 1: two iterations from x=0 to a=2.
        load_a(0, 1, 0, 2, 1);
        push_exp("c1", 32'd2, 32'hFFFF_FFFE, 32'd3, 32'd3, 32'd2, 32'd0, 32'd3);
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        chk("c1_busy", 32'(if_a.busy), 32'd1);
        wait_and_check(0);
        tick();
        chk("c1_pulse_1cyc", 32'(if_a.done), 32'd0);
        chk("c1_stable_x", if_a.xport, 32'd2);
        chk("c1_idle", 32'(if_a.busy), 32'd0);

        // Case 2: x0 == aport, no iterations.
        load_a(5, 7, 9, 5, 1);
        push_exp("c2", 32'd5, 32'd7, 32'd9, 32'd21, 32'd0, 32'd0, 32'd1);
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        wait_and_check(0);

        // Case 3: dx=0 never reaches a; iteration cap of 16 fires.
        if_m.x0 = 32'sd0; if_m.y0 = 32'sd1; if_m.u0 = 32'sd0; if_m.aport = 32'sd5; if_m.dxport = 32'sd0;
        push_exp("c3", 32'd0, 32'd1, 32'd0, 32'd1, 32'd16, 32'd1, 32'd17);
        if_m.start = 1'b1;
        tick();
        if_m.start = 1'b0;
        wait_and_check(1);
        tick();
        chk("c3_timeout_held", 32'(if_m.timeout), 32'd1);
        if_m.aport = 32'sd0;
        push_exp("c3b", 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1);
        if_m.start = 1'b1;
        tick();
        if_m.start = 1'b0;
        chk("c3_timeout_clr", 32'(if_m.timeout), 32'd0);
        wait_and_check(1);

        // Case 4: 8-bit u overflow, wrap or saturate.
        if_b.x0 = 8'sd0; if_b.y0 = 8'sd100; if_b.u0 = 8'sd0; if_b.aport = 8'sd1; if_b.dxport = 8'sd1;
`ifdef DIFFEQ_SAT_EN
        push_exp("c4", 32'h01, 32'h64, 32'h80, 32'hE5, 32'd1, 32'd0, 32'd2);
`else
        push_exp("c4", 32'h01, 32'h64, 32'hD4, 32'h39, 32'd1, 32'd0, 32'd2);
`endif
        if_b.start = 1'b1;
        tick();
        if_b.start = 1'b0;
        wait_and_check(2);

        // Case 5: reset mid-run aborts without done, then a clean rerun.
        load_a(0, 1, 0, 2, 1);
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("c5_busy", 32'(if_a.busy), 32'd0);
        chk("c5_done", 32'(if_a.done), 32'd0);
        chk("c5_x",    if_a.xport, 32'd0);
        chk("c5_y",    if_a.yport, 32'd0);
        chk("c5_u",    if_a.uport, 32'd0);
        chk("c5_iter", 32'(if_a.iter_count), 32'd0);
        tick();
        chk("c5_no_done", 32'(if_a.done), 32'd0);
        push_exp("c5", 32'd2, 32'hFFFF_FFFE, 32'd3, 32'd3, 32'd2, 32'd0, 32'd3);
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        wait_and_check(0);

        // Case 6: start held high; mid-run starts and input changes ignored,
        // second run accepted at the done-cycle edge with the new y0.
        load_a(0, 1, 0, 2, 1);
        push_exp("c6a", 32'd2, 32'hFFFF_FFFE, 32'd3, 32'd3, 32'd2, 32'd0, 32'd3);
        if_a.start = 1'b1;
        tick();
        if_a.y0 = 32'sd5;
        wait_and_check(0);
        push_exp("c6b", 32'd2, 32'hFFFF_FFF6, 32'd15, 32'd7, 32'd2, 32'd0, 32'd3);
        tick();
        if_a.start = 1'b0;
        chk("c6_restart_busy", 32'(if_a.busy), 32'd1);
        chk("c6_restart_done", 32'(if_a.done), 32'd0);
        chk("c6_restart_iter", 32'(if_a.iter_count), 32'd0);
        wait_and_check(0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
